div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_sign_fixup.sv | 34 +++
 rtl/div_sequencer.sv | 177 +++++++++++++++++
 tb/tb_div_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the division sequencer: default sizing and FSM state type.
// Signed operation is enabled by defining DIV_SIGNED_EN at build time.
package div_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Two's complement negation used by the signed magnitude/fixup path.
  function automatic logic [DEFAULT_WIDTH-1:0] negate32(input logic [DEFAULT_WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/div_sign_fixup.sv
// Signed wrapper logic around an unsigned divider core: operand magnitudes in,
// truncation-toward-zero sign fixup out. Only instantiated when DIV_SIGNED_EN is defined.
module div_sign_fixup
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] core_q,
  input  logic [WIDTH-1:0] core_r,
  output logic [WIDTH-1:0] mag_n,
  output logic [WIDTH-1:0] mag_d,
  output logic [WIDTH-1:0] fix_q,
  output logic [WIDTH-1:0] fix_r
);

  logic n_neg;
  logic d_neg;
  logic q_neg;

  assign n_neg = n[WIDTH-1];
  assign d_neg = d[WIDTH-1];
  assign q_neg = n_neg ^ d_neg;

  // The most negative value negates to itself, which read unsigned is exactly 2^(WIDTH-1).
  assign mag_n = n_neg ? (~n + 1'b1) : n;
  assign mag_d = d_neg ? (~d + 1'b1) : d;

  // Remainder follows the dividend so that q*d + r == n with q rounded toward zero.
  assign fix_q = q_neg ? (~core_q + 1'b1) : core_q;
  assign fix_r = n_neg ? (~core_r + 1'b1) : core_r;

endmodule

// File: rtl/div_sequencer.sv
// Request/response sequencer for an external unsigned long-division core, with
// divide-by-zero bypass and a wait timeout. Define DIV_SIGNED_EN for two's complement operands.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_n,
  input  logic [WIDTH-1:0] in_d,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_div_zero,
  output logic             out_timeout,

  output logic             core_rst,
  output logic             core_valid,
  output logic [WIDTH-1:0] core_n,
  output logic [WIDTH-1:0] core_d,
  input  logic             core_ready,
  input  logic             core_div_zero_err,
  input  logic [WIDTH-1:0] core_q,
  input  logic [WIDTH-1:0] core_r
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CNT_W-1:0] wait_cnt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             div_zero_reg;
  logic             timeout_reg;

  logic [WIDTH-1:0] op_n;
  logic [WIDTH-1:0] op_d;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

  logic accept;
  logic d_is_zero;
  logic ready_sampled;
  logic timed_out;

`ifdef DIV_SIGNED_EN
  div_sign_fixup #(
    .WIDTH (WIDTH)
  ) u_sign_fixup (
    .n      (n_reg),
    .d      (d_reg),
    .core_q (core_q),
    .core_r (core_r),
    .mag_n  (op_n),
    .mag_d  (op_d),
    .fix_q  (res_q),
    .fix_r  (res_r)
  );
`else
  assign op_n  = n_reg;
  assign op_d  = d_reg;
  assign res_q = core_q;
  assign res_r = core_r;
`endif

  assign accept    = in_valid && (state == IDLE);
  assign d_is_zero = (in_d == '0);

  // The core's ready may still reflect the previous job in the first WAIT cycle, so it is blanked.
  assign ready_sampled = (state == WAIT) && (wait_cnt != '0) && core_ready;
  assign timed_out     = (state == WAIT) && (wait_cnt == LAST_WAIT) && !ready_sampled;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = d_is_zero ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (ready_sampled || timed_out) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand capture, wait counting and result/flag registers; results stay frozen through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg        <= '0;
      d_reg        <= '0;
      wait_cnt     <= '0;
      q_reg        <= '0;
      r_reg        <= '0;
      div_zero_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            n_reg        <= in_n;
            d_reg        <= in_d;
            wait_cnt     <= '0;
            q_reg        <= '0;
            r_reg        <= '0;
            div_zero_reg <= d_is_zero;
            timeout_reg  <= 1'b0;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (ready_sampled) begin
            q_reg        <= res_q;
            r_reg        <= res_r;
            div_zero_reg <= core_div_zero_err;
          end else if (timed_out) begin
            q_reg       <= '0;
            r_reg       <= '0;
            timeout_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign out_q        = q_reg;
  assign out_r        = r_reg;
  assign out_div_zero = div_zero_reg;
  assign out_timeout  = timeout_reg;

  // Reset restarts the core immediately, independent of the registered state.
  assign core_rst   = reset || (state == ISSUE);
  assign core_valid = (state == WAIT);
  assign core_n     = op_n;
  assign core_d     = op_d;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: behavioural divider core plus an arithmetic reference model.
// Expectations follow DIV_SIGNED_EN when it is defined for the build.
module tb_div_sequencer;

  localparam int W  = 32;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_n;
  logic [W-1:0] in_d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_q;
  logic [W-1:0] out_r;
  logic         out_div_zero;
  logic         out_timeout;
  logic         core_rst;
  logic         core_valid;
  logic [W-1:0] core_n;
  logic [W-1:0] core_d;
  logic         core_ready;
  logic         core_div_zero_err;
  logic [W-1:0] core_q;
  logic [W-1:0] core_r;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_sequencer #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_n              (in_n),
    .in_d              (in_d),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_q             (out_q),
    .out_r             (out_r),
    .out_div_zero      (out_div_zero),
    .out_timeout       (out_timeout),
    .core_rst          (core_rst),
    .core_valid        (core_valid),
    .core_n            (core_n),
    .core_d            (core_d),
    .core_ready        (core_ready),
    .core_div_zero_err (core_div_zero_err),
    .core_q            (core_q),
    .core_r            (core_r)
  );

  // Behavioural unsigned core: ready 'lat' enabled cycles after restart, optional stale-ready glitch.
  int           lat         = 1;
  bit           never_ready = 1'b0;
  bit           glitch      = 1'b0;
  int           m_cnt       = 0;
  logic         m_ready     = 1'b0;
  logic [W-1:0] m_q         = '0;
  logic [W-1:0] m_r         = '0;
  logic         m_err       = 1'b0;
  logic         glitch_now;

  always @(posedge clk) begin
    if (core_rst) begin
      m_cnt   <= 0;
      m_ready <= 1'b0;
    end else if (core_valid && !m_ready && !never_ready) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 >= lat) begin
        m_ready <= 1'b1;
        m_err   <= (core_d == '0);
        m_q     <= (core_d == '0) ? '0 : core_n / core_d;
        m_r     <= (core_d == '0) ? '0 : core_n % core_d;
      end
    end
  end

  assign glitch_now        = glitch && core_valid && (m_cnt == 0) && !m_ready;
  assign core_ready        = m_ready | glitch_now;
  assign core_q            = glitch_now ? 32'hDEAD_BEEF : m_q;
  assign core_r            = glitch_now ? 32'h0BAD_F00D : m_r;
  assign core_div_zero_err = glitch_now ? 1'b1 : m_err;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic result plus the operands the core is expected to see.
  task automatic ref_div(input logic [W-1:0] n, input logic [W-1:0] d,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                         output logic [W-1:0] cn, output logic [W-1:0] cd);
`ifdef DIV_SIGNED_EN
    longint sn, sd, lq, lr;
    sn = longint'($signed(n));
    sd = longint'($signed(d));
    cn = W'(sn < 0 ? -sn : sn);
    cd = W'(sd < 0 ? -sd : sd);
    if (d == '0) begin
      q = '0; r = '0; dz = 1'b1;
    end else begin
      lq = sn / sd;
      lr = sn % sd;
      q  = W'(lq);
      r  = W'(lr);
      dz = 1'b0;
    end
`else
    cn = n;
    cd = d;
    if (d == '0) begin
      q = '0; r = '0; dz = 1'b1;
    end else begin
      q = n / d; r = n % d; dz = 1'b0;
    end
`endif
  endtask

  task automatic apply_stimulus(input logic [W-1:0] n, input logic [W-1:0] d);
    check_output("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_n     = n;
    in_d     = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("out_valid_drop", 64'(out_valid), 64'(0));
    check_output("in_ready_back", 64'(in_ready), 64'(1));
  endtask

  task automatic run_div(input logic [W-1:0] n, input logic [W-1:0] d, input int latency,
                         input bit no_ready, input bit glitch_en);
    logic [W-1:0] eq, er, ecn, ecd;
    logic         edz, eto;
    int           waits, unstable;
    bit           seen;
    ref_div(n, d, eq, er, edz, ecn, ecd);
    eto = (d != '0) && no_ready;
    if (eto) begin
      eq = '0; er = '0; edz = 1'b0;
    end
    lat = latency; never_ready = no_ready; glitch = glitch_en;
    apply_stimulus(n, d);
    if (d == '0) begin
      check_output("dz_no_core_rst", 64'(core_rst), 64'(0));
      check_output("dz_valid_next", 64'(out_valid), 64'(1));
    end else begin
      check_output("issue_core_rst", 64'(core_rst), 64'(1));
      check_output("issue_core_valid", 64'(core_valid), 64'(0));
      check_output("issue_core_n", 64'(core_n), 64'(ecn));
      check_output("issue_core_d", 64'(core_d), 64'(ecd));
      waits = 0; unstable = 0; seen = 1'b0;
      for (int i = 0; i < TO + 20 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
        else begin
          if (core_valid) waits++;
          if (core_n !== ecn || core_d !== ecd || core_rst !== 1'b0) unstable++;
        end
      end
      check_output("out_valid_seen", 64'(out_valid), 64'(1));
      check_output("wait_operands_stable", 64'(unstable), 64'(0));
      if (no_ready) check_output("timeout_wait_cycles", 64'(waits), 64'(TO));
      check_output("done_core_valid", 64'(core_valid), 64'(0));
    end
    check_output("done_in_ready", 64'(in_ready), 64'(0));
    check_output("out_q", 64'(out_q), 64'(eq));
    check_output("out_r", 64'(out_r), 64'(er));
    check_output("out_div_zero", 64'(out_div_zero), 64'(edz));
    check_output("out_timeout", 64'(out_timeout), 64'(eto));
    release_result();
  endtask

  initial begin
    logic [W-1:0] rn, rd;
    logic [W-1:0] hq, hr, hcn, hcd;
    logic         hdz;
    int           hold_bad, stray;
    reset = 1'b1; in_valid = 1'b0; in_n = '0; in_d = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_in_ready", 64'(in_ready), 64'(1));
    check_output("rst_out_valid", 64'(out_valid), 64'(0));
    check_output("rst_out_q", 64'(out_q), 64'(0));
    check_output("rst_out_r", 64'(out_r), 64'(0));
    check_output("rst_flags", 64'({out_div_zero, out_timeout}), 64'(0));
    check_output("rst_core_valid", 64'(core_valid), 64'(0));
    check_output("rst_core_rst", 64'(core_rst), 64'(1));
    reset = 1'b0;
    @(negedge clk);
    check_output("idle_core_rst", 64'(core_rst), 64'(0));

    // Directed cases: basic divide, sign corners, divide by zero, blanking, timeout.
    run_div(32'd100, 32'd7, 33, 1'b0, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 5, 1'b0, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 3, 1'b0, 1'b0);
    run_div(32'd5, 32'd0, 1, 1'b0, 1'b0);
    run_div(32'd0, 32'd9, 2, 1'b0, 1'b0);
    run_div(32'd7, 32'd100, 1, 1'b0, 1'b0);
    run_div(32'd1000, 32'd3, 4, 1'b0, 1'b1);
    run_div(32'd50, 32'd5, 1, 1'b1, 1'b0);
    run_div(32'd12345, 32'hFFFF_FFFD, 63, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      rn = $urandom;
      rd = $urandom;
      case ($urandom_range(0, 3))
        0: rd = rd >> $urandom_range(8, 31);
        1: rd = '0;
        2: rd = W'($urandom_range(1, 15));
        default: ;
      endcase
      run_div(rn, rd, int'($urandom_range(1, 40)), 1'b0, 1'b0);
    end

    // Hold in DONE with a competing request that must be ignored.
    ref_div(32'd77, 32'd5, hq, hr, hdz, hcn, hcd);
    lat = 2; never_ready = 1'b0; glitch = 1'b0;
    apply_stimulus(32'd77, 32'd5);
    for (int i = 0; i < TO && !out_valid; i++) @(negedge clk);
    check_output("hold_valid_seen", 64'(out_valid), 64'(1));
    hold_bad = 0;
    in_valid = 1'b1; in_n = 32'd999; in_d = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_q !== hq || out_r !== hr || out_div_zero !== hdz)
        hold_bad++;
    end
    check_output("hold_stable", 64'(hold_bad), 64'(0));
    check_output("hold_q", 64'(out_q), 64'(hq));
    in_valid = 1'b0;
    release_result();

    // Reset during WAIT discards the request.
    lat = 40; never_ready = 1'b0; glitch = 1'b0;
    apply_stimulus(32'd1000, 32'd7);
    repeat (4) @(negedge clk);
    check_output("mid_in_wait", 64'(core_valid), 64'(1));
    reset = 1'b1;
    #1;
    check_output("mid_core_rst_comb", 64'(core_rst), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    check_output("mid_in_ready", 64'(in_ready), 64'(1));
    check_output("mid_core_valid", 64'(core_valid), 64'(0));
    check_output("mid_out_q", 64'(out_q), 64'(0));
    stray = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    check_output("mid_no_out_valid", 64'(stray), 64'(0));
    run_div(32'd81, 32'd9, 6, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
